// File: rtl/ad_acq_window_pkg.sv
// Shared definitions for the trigger-gated ADC acquisition window.
package ad_acq_window_pkg;

  // Window controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_ACQ   = 2'd2,
    ST_DONE  = 2'd3
  } acq_state_t;

  // Guard bits so a sum of 2^DEC_MAX_LOG2 full-scale samples cannot wrap
  localparam int ACC_EXTRA    = 3;
  localparam int DEC_MAX_LOG2 = 3;
  localparam int SUB_W        = DEC_MAX_LOG2 + 1;

  // Number of input samples folded into one output for a given exponent
  function automatic logic [SUB_W-1:0] dec_count(input logic [1:0] dec_log2);
    return SUB_W'(1) << dec_log2;
  endfunction

endpackage

// File: rtl/ad_boxcar_avg.sv
// Boxcar averager: sums 2^dec_log2 samples, emits the truncated mean and
// restarts in the same cycle so back-to-back input never loses a sample.
module ad_boxcar_avg
  import ad_acq_window_pkg::*;
#(
  parameter int DW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [1:0]    dec_log2,
  input  logic [DW-1:0] din,
  output logic          fire,
  output logic [DW-1:0] dout,
  output logic          dout_en
);

  localparam int AW = DW + ACC_EXTRA;

  logic [AW-1:0]    acc_reg;
  logic [AW-1:0]    sum_next;
  logic [SUB_W-1:0] sub_reg;
  logic [SUB_W-1:0] sub_next;

  // Sum including the current sample; fire when this sample completes a group
  always_comb begin
    sum_next = acc_reg + AW'(din);
    sub_next = sub_reg + SUB_W'(1);
    fire     = en && !clr && (sub_next == dec_count(dec_log2));
  end

  // Accumulate, emit the average on group completion, clear wins over enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg <= '0;
      sub_reg <= '0;
      dout    <= '0;
      dout_en <= 1'b0;
    end else begin
      dout_en <= 1'b0;
      if (clr) begin
        acc_reg <= '0;
        sub_reg <= '0;
      end else if (en) begin
        if (fire) begin
          acc_reg <= '0;
          sub_reg <= '0;
          dout    <= DW'(sum_next >> dec_log2);
          dout_en <= 1'b1;
        end else begin
          acc_reg <= sum_next;
          sub_reg <= sub_next;
        end
      end
    end
  end

endmodule

// File: rtl/ad_acq_window.sv
// Trigger-gated acquisition window: after a trigger, skip 'delay' input
// samples, then produce 'length' boxcar-averaged output samples.
module ad_acq_window
  import ad_acq_window_pkg::*;
#(
  parameter int DW = 14,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_en,
  input  logic          trig,
  input  logic          abort,
  input  logic [CW-1:0] delay,
  input  logic [CW-1:0] length,
  input  logic [1:0]    dec_log2,
  output logic [DW-1:0] dout,
  output logic          dout_en,
  output logic          busy,
  output logic          done,
  output logic          retrig_err
);

  acq_state_t    state_reg;
  acq_state_t    state_next;
  logic [CW-1:0] dly_cnt_reg;
  logic [CW-1:0] out_cnt_reg;
  logic [CW-1:0] len_reg;
  logic [1:0]    dec_reg;
  logic          retrig_err_reg;
  logic          done_reg;

  logic trig_ok;
  logic trig_rejected;
  logic avg_en;
  logic avg_clr;
  logic avg_fire;
  logic last_out;

  // Trigger qualification and datapath controls; abort always dominates
  always_comb begin
    trig_ok       = trig && !abort && (state_reg == ST_IDLE);
    trig_rejected = trig && !abort && (state_reg != ST_IDLE);
    avg_en        = (state_reg == ST_ACQ) && din_en;
    avg_clr       = abort || trig_ok;
    last_out      = avg_fire && ((out_cnt_reg + CW'(1)) == len_reg);
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (trig_ok) begin
          state_next = (length == '0) ? ST_DONE : ST_DELAY;
        end
      end
      ST_DELAY: begin
        // The sample present in the deciding cycle is dropped
        if (dly_cnt_reg == '0) begin
          state_next = ST_ACQ;
        end
      end
      ST_ACQ: begin
        if (last_out) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (abort) begin
      state_next = ST_IDLE;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Shadow copies of the window parameters, captured only on an accepted trigger
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_reg <= '0;
      dec_reg <= '0;
    end else if (trig_ok) begin
      len_reg <= length;
      dec_reg <= dec_log2;
    end
  end

  // Delay counter: counts valid input samples down while in DELAY
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly_cnt_reg <= '0;
    end else if (abort) begin
      dly_cnt_reg <= '0;
    end else if (trig_ok) begin
      dly_cnt_reg <= delay;
    end else if ((state_reg == ST_DELAY) && din_en && (dly_cnt_reg != '0)) begin
      dly_cnt_reg <= dly_cnt_reg - CW'(1);
    end
  end

  // Output counter: one step per averaged sample produced
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_cnt_reg <= '0;
    end else if (avg_clr) begin
      out_cnt_reg <= '0;
    end else if (avg_fire) begin
      out_cnt_reg <= out_cnt_reg + CW'(1);
    end
  end

  // Sticky retrigger error and the registered end-of-window pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retrig_err_reg <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      if (trig_rejected) begin
        retrig_err_reg <= 1'b1;
      end else if (trig_ok) begin
        retrig_err_reg <= 1'b0;
      end
      done_reg <= (state_reg == ST_DONE) && !abort;
    end
  end

  ad_boxcar_avg #(
    .DW (DW)
  ) u_avg (
    .clk      (clk),
    .rst      (rst),
    .clr      (avg_clr),
    .en       (avg_en),
    .dec_log2 (dec_reg),
    .din      (din),
    .fire     (avg_fire),
    .dout     (dout),
    .dout_en  (dout_en)
  );

  // busy stays up through the done pulse so it falls the cycle after done
  assign busy       = (state_reg != ST_IDLE) || done_reg;
  assign done       = done_reg;
  assign retrig_err = retrig_err_reg;

endmodule

// File: doc/ad_acq_window.md
# ad_acq_window

Trigger-gated acquisition window for the ADC sample stream. It sits directly downstream of the LTC2150 DDIO capture stage in the high-speed clock domain. On each trigger it skips a programmable number of input samples, then emits a programmable number of output samples. Each output sample is the boxcar average of 2^dec_log2 consecutive input samples. Data is offset-binary, unsigned throughout.

## Interface
Parameters:
- DW, 14: sample width (input and output)
- CW, 16: width of the delay and length counters

Ports:
- clk  in  1  ADC sample clock; the single clock of the block
- rst  in  1  asynchronous, active-low reset
- din  in  DW  sample from the capture stage
- din_en  in  1  din valid this cycle
- trig  in  1  start pulse, single-cycle, synchronous to clk
- abort  in  1  synchronous cancel
- delay  in  CW  input samples to discard after trigger
- length  in  CW  output samples to produce
- dec_log2  in  2  decimation exponent; averages 1/2/4/8 samples
- dout  out  DW  averaged sample
- dout_en  out  1  dout valid, one cycle per output
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at window end
- retrig_err  out  1  sticky flag: trig arrived while busy

## Operation
- The FSM has four states: IDLE, DELAY, ACQ, DONE.
- **IDLE**
  - trig loads delay, length and dec_log2 into shadow registers.
  - If length≠0, go to DELAY; if length==0, go to DONE, which gives a done pulse and no outputs.
  - Parameter inputs are ignored outside this load event.
- **DELAY**
  - Each din_en with dly_cnt>0 decrements dly_cnt; that sample is discarded.
  - When dly_cnt==0 the next state is ACQ, regardless of din_en.
  - A sample arriving in the cycle the transition is decided is discarded.
- **ACQ**
  - Each din_en adds din into a (DW+3)-bit accumulator and increments the sub-counter.
  - When the sub-counter reaches 2^dec_log2, the averaged sample is registered:
    - dout = acc_with_current_sample >> dec_log2, truncated with no rounding.
    - dout_en pulses for one cycle.
  - The accumulator restarts from 0 in the same cycle, so there is no lost sample and no bubble.
  - The output counter increments on each output; when it reaches length, the next state is DONE.
- **DONE**: done=1 for one cycle, then IDLE.
- **trig while busy**: ignored; sets retrig_err. retrig_err clears on the next accepted trig.
- **abort**: from any state, go to IDLE next cycle.
  - Accumulator and counters clear; no done pulse; any partial average is dropped.
- **Simultaneous events**:
  - abort wins over trig in the same cycle.
  - In IDLE, trig+abort means no window starts.
- **Reset mid-window**: all outputs return to reset values immediately; state goes to IDLE.
- **Reset values**: dout=0, dout_en=0, busy=0, done=0, retrig_err=0; all counters and the accumulator are 0.

## Timing
- trig sampled at cycle t: busy=1 and state DELAY at t+1.
- With delay=0, ACQ at t+2; the first din_en captured is at t+2 or later.
- dout/dout_en are registered: output is valid at cycle k+1 when the completing sample has din_en at cycle k.
- done is asserted the cycle after the final dout_en; busy drops the cycle after done.
- Throughput: one input per clock, sustained, with no stalls. No backpressure is supported.

## Structure
- A shared package holds:
  - the state enum (IDLE/DELAY/ACQ/DONE);
  - ACC_EXTRA=3 (accumulator guard bits);
  - DEC_MAX_LOG2=3.
- Natural sub-module: ad_boxcar_avg.
  - Contains the accumulator, sub-counter, shift and output register.
  - Controlled by an enable and a clear from the FSM.
- FSM and delay/length counters stay in the top level.

## Test plan
- **Basic window**: delay=3, length=4, dec_log2=0, din ramp 0,1,2,… with din_en held high.
  - Response: outputs are the ramp values following the 3 discarded samples (post-transition alignment per the DELAY rule), 4 dout_en pulses, then done one cycle after the last.
- **Decimation**: dec_log2=2, length=2, delay=0, samples 100,101,102,103,200,201,202,203.
  - Response: dout=101 then 201 (truncated averages of 406/4 and 806/4); done follows.
- **Full scale**: 8 samples of 16383 with dec_log2=3.
  - Response: dout=16383, with no accumulator overflow.
- **Gapped input**: din_en toggles every other cycle, same stimulus as the decimation case.
  - Response: identical values; dout_en spacing doubles.
- **Retrigger and abort**:
  - trig during ACQ gives retrig_err=1 and the window is unaffected.
  - abort mid-ACQ gives busy=0 next cycle, no done, and no further dout_en.
  - A new trig clears retrig_err.
- **Edge cases**:
  - length=0 gives a done pulse at t+2 and no dout_en.
  - rst asserted mid-ACQ zeroes all outputs asynchronously.
  - trig+abort in the same cycle starts nothing.
